// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default bit timing and parity modes.
// Kept separate so a matching receiver can reuse the same encodings.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   // 50 MHz system clock at 115200 baud
   localparam int UART_CLKS_PER_BIT_DEFAULT = 434;

   localparam int UART_PARITY_NONE = 0;
   localparam int UART_PARITY_EVEN = 1;

   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last count of each bit.
// The tick is a flop output so downstream state decisions see a clean strobe.
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick,
   output logic pre_tick
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_s;
   logic             tick_r;
   logic             tick_s;

   // Next count and look-ahead tick so the tick itself can be registered
   always_comb begin
      count_s = count_r;
      if (restart) begin
         count_s = {CNT_W{1'b0}};
      end else if (count_r == CNT_LAST) begin
         count_s = {CNT_W{1'b0}};
      end else begin
         count_s = count_r + CNT_W'(1);
      end
      tick_s = (count_s == CNT_LAST);
   end

   // Counter and tick registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_r <= {CNT_W{1'b0}};
         tick_r  <= 1'b0;
      end else begin
         count_r <= count_s;
         tick_r  <= tick_s;
      end
   end

   assign tick     = tick_r;
   assign pre_tick = (count_r == CNT_PRE);

endmodule

// File: rtl/uart_byte_tx.sv
// Byte-wide UART transmitter with a one-byte holding register, optional even parity,
// and back-to-back frames when the next byte is already held at the end of STOP.
module uart_byte_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
   parameter int PARITY_EN    = UART_PARITY_NONE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   input  logic       Ready_Byte,
   output logic       Tx_busy,
   output logic       tx,
   output logic       tx_done
);

   localparam logic PAR_ON = (PARITY_EN == UART_PARITY_EVEN);

   uart_state_e state_r;
   uart_state_e state_s;
   logic [7:0]  hold_r;
   logic [7:0]  hold_s;
   logic [7:0]  data_r;
   logic [7:0]  data_s;
   logic [2:0]  idx_r;
   logic [2:0]  idx_s;
   logic        busy_r;
   logic        busy_s;
   logic        tx_r;
   logic        tx_s;
   logic        done_r;
   logic        done_s;
   logic        restart_s;
   logic        tick_s;
   logic        pre_tick_s;

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk      (clk),
      .rst      (rst),
      .restart  (restart_s),
      .tick     (tick_s),
      .pre_tick (pre_tick_s)
   );

   // Holding-register acceptance, frame sequencing and next line level
   always_comb begin
      state_s = state_r;
      hold_s  = hold_r;
      data_s  = data_r;
      idx_s   = idx_r;
      busy_s  = busy_r;
      tx_s    = 1'b1;

      // Acceptance and hand-off are mutually exclusive: one needs busy low, the other high
      if (Ready_Byte && !busy_r) begin
         hold_s = din;
         busy_s = 1'b1;
      end else begin
         hold_s = hold_r;
      end

      case (state_r)
         ST_IDLE: begin
            if (busy_r) begin
               state_s = ST_START;
               data_s  = hold_r;
               busy_s  = 1'b0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (tick_s) begin
               state_s = ST_DATA;
               idx_s   = 3'd0;
            end else begin
               state_s = ST_START;
            end
         end
         ST_DATA: begin
            if (tick_s) begin
               if (idx_r == 3'd7) begin
                  state_s = PAR_ON ? ST_PARITY : ST_STOP;
               end else begin
                  idx_s = idx_r + 3'd1;
               end
            end else begin
               state_s = ST_DATA;
            end
         end
         ST_PARITY: begin
            if (tick_s) begin
               state_s = ST_STOP;
            end else begin
               state_s = ST_PARITY;
            end
         end
         ST_STOP: begin
            if (tick_s) begin
               if (busy_r) begin
                  state_s = ST_START;
                  data_s  = hold_r;
                  busy_s  = 1'b0;
               end else begin
                  state_s = ST_IDLE;
               end
            end else begin
               state_s = ST_STOP;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      // Line level is decoded from the next state so tx leaves a flop
      case (state_s)
         ST_IDLE:   tx_s = 1'b1;
         ST_START:  tx_s = 1'b0;
         ST_DATA:   tx_s = data_s[idx_s];
         ST_PARITY: tx_s = even_parity(data_s);
         ST_STOP:   tx_s = 1'b1;
         default:   tx_s = 1'b1;
      endcase

      restart_s = (state_s != state_r) || (state_r == ST_IDLE);
      done_s    = (state_r == ST_STOP) && pre_tick_s;
   end

   // State, buffers and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         hold_r  <= 8'h00;
         data_r  <= 8'h00;
         idx_r   <= 3'd0;
         busy_r  <= 1'b0;
         tx_r    <= 1'b1;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         hold_r  <= hold_s;
         data_r  <= data_s;
         idx_r   <= idx_s;
         busy_r  <= busy_s;
         tx_r    <= tx_s;
         done_r  <= done_s;
      end
   end

   assign Tx_busy = busy_r;
   assign tx      = tx_r;
   assign tx_done = done_r;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: three configurations checked every cycle against a line-sample
// queue model, plus a vector table and hand-written multi-cycle sequences.
module tb_uart_byte_tx;

   logic       clk;
   logic       rst;
   logic [7:0] din_a [3];
   logic [2:0] rdy_a;
   logic [2:0] tx_v;
   logic [2:0] busy_v;
   logic [2:0] done_v;

   int checks = 0;
   int errors = 0;

   uart_byte_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0)) dut0 (
      .clk(clk), .rst(rst), .din(din_a[0]), .Ready_Byte(rdy_a[0]),
      .Tx_busy(busy_v[0]), .tx(tx_v[0]), .tx_done(done_v[0]));
   uart_byte_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dut1 (
      .clk(clk), .rst(rst), .din(din_a[1]), .Ready_Byte(rdy_a[1]),
      .Tx_busy(busy_v[1]), .tx(tx_v[1]), .tx_done(done_v[1]));
   uart_byte_tx #(.CLKS_PER_BIT(2), .PARITY_EN(0)) dut2 (
      .clk(clk), .rst(rst), .din(din_a[2]), .Ready_Byte(rdy_a[2]),
      .Tx_busy(busy_v[2]), .tx(tx_v[2]), .tx_done(done_v[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int cpb_of(input int i);
      return (i == 2) ? 2 : 4;
   endfunction

   function automatic bit par_of(input int i);
      return (i == 1);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference model: future line samples per instance, one entry per clock
   bit         line_q [3][$];
   bit         hold_full [3];
   logic [7:0] hold_byte [3];

   task automatic push_frame(input int i, input logic [7:0] b);
      bit lv [$];
      lv.push_back(1'b0);
      for (int k = 0; k < 8; k++) lv.push_back(b[k]);
      if (par_of(i)) lv.push_back(^b);
      lv.push_back(1'b1);
      foreach (lv[k]) repeat (cpb_of(i)) line_q[i].push_back(lv[k]);
   endtask

   always @(posedge clk or negedge rst) begin
      for (int i = 0; i < 3; i++) begin
         bit was_full;
         if (!rst) begin
            line_q[i].delete();
            hold_full[i] = 1'b0;
         end else begin
            was_full = hold_full[i];
            if (line_q[i].size() > 0) void'(line_q[i].pop_front());
            if (was_full && line_q[i].size() == 0) begin
               push_frame(i, hold_byte[i]);
               hold_full[i] = 1'b0;
            end
            if (rdy_a[i] && !was_full) begin
               hold_full[i] = 1'b1;
               hold_byte[i] = din_a[i];
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int j = 0; j < 3; j++) begin
         bit exp_tx;
         bit exp_done;
         exp_tx   = (line_q[j].size() > 0) ? line_q[j][0] : 1'b1;
         exp_done = (line_q[j].size() == 1);
         check($sformatf("model_i%0d{tx,busy,done}", j),
               {29'd0, tx_v[j], busy_v[j], done_v[j]},
               {29'd0, exp_tx, hold_full[j], exp_done});
      end
   end

   typedef struct {
      int         inst;
      logic [7:0] din;
      int         nbits;
      logic [10:0] bits;
      int         len;
   } vec_t;

   vec_t vecs [6];

   task automatic strobe(input int inst, input logic [7:0] d);
      @(negedge clk);
      din_a[inst] = d;
      rdy_a[inst] = 1'b1;
      @(negedge clk);
      rdy_a[inst] = 1'b0;
   endtask

   task automatic wait_start(input int inst, input int budget, output int waited);
      waited = -1;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (tx_v[inst] == 1'b0) begin
            waited = k;
            break;
         end
      end
      if (waited < 0) begin
         checks++;
         errors++;
         $display("FAIL start_timeout inst=%0d actual=none expected=tx low within %0d", inst, budget);
      end
   endtask

   // Entered at the negedge of the first start-bit clock; samples mid-bit
   task automatic capture(input int inst, input int nbits, output logic [10:0] bits, output int len);
      int cpb;
      cpb  = cpb_of(inst);
      bits = 11'd0;
      len  = -1;
      for (int c = 0; c < nbits * cpb; c++) begin
         if (c % cpb == cpb / 2) bits[c / cpb] = tx_v[inst];
         if (done_v[inst] && len < 0) len = c + 1;
         @(negedge clk);
      end
   endtask

   task automatic back_to_back(input int inst, input logic [7:0] d1, input logic [7:0] d2,
                               input logic [10:0] exp_bits, input int exp_len);
      int         w;
      bit         seen;
      logic [10:0] bits;
      int         len;
      strobe(inst, d1);
      wait_start(inst, 8, w);
      din_a[inst] = d2;
      rdy_a[inst] = 1'b1;
      @(negedge clk);
      rdy_a[inst] = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 12 * cpb_of(inst); k++) begin
         if (done_v[inst]) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check($sformatf("b2b_done_seen_i%0d", inst), {31'd0, seen}, 32'd1);
      @(negedge clk);
      check($sformatf("b2b_gap_i%0d", inst), {31'd0, tx_v[inst]}, 32'd0);
      capture(inst, 10, bits, len);
      check($sformatf("b2b_bits_i%0d", inst), {21'd0, bits}, {21'd0, exp_bits});
      check($sformatf("b2b_len_i%0d", inst), len, exp_len);
   endtask

   initial begin
      int          w;
      int          zeros;
      logic [10:0] bits;
      int          len;

      vecs[0] = '{0, 8'hA5, 10, 11'h34A, 40};
      vecs[1] = '{1, 8'h07, 11, 11'h60E, 44};
      vecs[2] = '{1, 8'hA5, 11, 11'h54A, 44};
      vecs[3] = '{0, 8'h3C, 10, 11'h278, 40};
      vecs[4] = '{2, 8'hFF, 10, 11'h3FE, 20};
      vecs[5] = '{2, 8'h00, 10, 11'h200, 20};

      rst   = 1'b0;
      rdy_a = 3'b000;
      for (int i = 0; i < 3; i++) din_a[i] = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_tx",   {29'd0, tx_v},   32'd7);
      check("reset_busy", {29'd0, busy_v}, 32'd0);
      check("reset_done", {29'd0, done_v}, 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 6; v++) begin
         strobe(vecs[v].inst, vecs[v].din);
         check($sformatf("vec%0d_busy", v), {31'd0, busy_v[vecs[v].inst]}, 32'd1);
         wait_start(vecs[v].inst, 8, w);
         check($sformatf("vec%0d_start_lat", v), w, 0);
         capture(vecs[v].inst, vecs[v].nbits, bits, len);
         check($sformatf("vec%0d_bits", v), {21'd0, bits}, {21'd0, vecs[v].bits});
         check($sformatf("vec%0d_len", v), len, vecs[v].len);
      end

      back_to_back(0, 8'h55, 8'hC3, 11'h386, 40);
      back_to_back(2, 8'hFF, 8'h00, 11'h200, 20);

      // Overrun: 0x11 waits in the holding register while 0x22 is strobed
      strobe(0, 8'h5A);
      wait_start(0, 8, w);
      din_a[0] = 8'h11;
      rdy_a[0] = 1'b1;
      @(negedge clk);
      check("ovr_busy_after_0x11", {31'd0, busy_v[0]}, 32'd1);
      din_a[0] = 8'h22;
      repeat (3) @(negedge clk);
      rdy_a[0] = 1'b0;
      check("ovr_busy_held", {31'd0, busy_v[0]}, 32'd1);
      for (int k = 0; k < 60; k++) begin
         if (done_v[0]) break;
         @(negedge clk);
      end
      @(negedge clk);
      capture(0, 10, bits, len);
      check("ovr_second_frame", {21'd0, bits}, {21'd0, 11'h222});
      zeros = 0;
      for (int k = 0; k < 50; k++) begin
         if (tx_v[0] == 1'b0) zeros++;
         @(negedge clk);
      end
      check("ovr_no_0x22", zeros, 0);

      // Reset in the middle of data bit 3 of 0xF0 (bit 3 is a zero on the line)
      strobe(0, 8'hF0);
      wait_start(0, 8, w);
      repeat (17) @(negedge clk);
      check("pre_rst_tx", {31'd0, tx_v[0]}, 32'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("rst_async_tx",   {29'd0, tx_v},   32'd7);
      check("rst_async_busy", {29'd0, busy_v}, 32'd0);
      check("rst_async_done", {29'd0, done_v}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      zeros = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (tx_v[0] == 1'b0) zeros++;
      end
      check("rst_no_resume", zeros, 0);

      // Random sparse strobes on all instances
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            rdy_a[i] = ($urandom_range(0, 99) < 8);
            din_a[i] = 8'($urandom_range(0, 255));
         end
      end
      rdy_a = 3'b000;

      // Producer keeps Ready_Byte high: frames must abut
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         rdy_a[2] = 1'b1;
         din_a[2] = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
      rdy_a = 3'b000;
      repeat (150) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_byte_tx.md
UART_BYTE_TX -- requirements
Module: uart_byte_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434 (50 MHz / 115200 baud), clocks per serial bit, legal range 2..65535.
REQ-002 The block SHALL have parameter PARITY_EN, default 0; 0 means no parity bit, 1 means an even parity bit is sent after the data bits.
REQ-003 The block SHALL have one clock and asynchronous active-low reset: clk (input, 1 bit, rising-edge system clock) and rst (input, 1 bit, asynchronous active-low reset).
REQ-004 The block SHALL have port din: input, 8 bits, byte to transmit.
REQ-005 The block SHALL have port Ready_Byte: input, 1 bit, strobe from the producer marking din as valid.
REQ-006 The block SHALL have port Tx_busy: output, 1 bit, high while the holding register is full and no new byte can be accepted.
REQ-007 The block SHALL have port tx: output, 1 bit, serial line, idle high.
REQ-008 The block SHALL have port tx_done: output, 1 bit, one-cycle pulse marking the end of each frame's stop bit.

Function
REQ-009 The block SHALL accept din into the 8-bit holding register at a rising edge where Ready_Byte=1 and Tx_busy=0, and SHALL set Tx_busy=1 from that edge.
REQ-010 The block SHALL ignore Ready_Byte while Tx_busy=1; the held byte SHALL NOT be overwritten and the new byte is dropped.
REQ-011 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP, all registered, with tx driven from a flop and never glitching.
REQ-012 In IDLE with the holding register full, the FSM SHALL move the holding byte to the shift register at the next edge, enter START, drive tx=0, and clear Tx_busy at that same edge.
REQ-013 Acceptance-to-start latency SHALL be exactly 1 clock: byte accepted at edge N, tx falls at edge N+1.
REQ-014 Each bit SHALL last exactly CLKS_PER_BIT clocks, timed by a baud counter running 0..CLKS_PER_BIT-1 that restarts on every state change.
REQ-015 The data bits SHALL be sent LSB first, 8 bits, tracked by a 3-bit index that ends at 7.
REQ-016 In PARITY (only when PARITY_EN=1), tx SHALL equal the XOR of the 8 data bits.
REQ-017 In STOP, tx SHALL be 1 for CLKS_PER_BIT clocks.
REQ-018 Frame length SHALL be 10*CLKS_PER_BIT clocks, or 11*CLKS_PER_BIT clocks with parity.
REQ-019 tx_done SHALL pulse for 1 clock on the final clock of STOP.
REQ-020 If the holding register is full at the end of STOP, the next state SHALL be START directly, with no extra idle cycle; otherwise the next state SHALL be IDLE.
REQ-021 If Ready_Byte=1 at the edge where the holding register empties, the byte SHALL be dropped, because acceptance uses the Tx_busy value sampled at that edge.
REQ-022 With this buffering, a producer that keeps Ready_Byte high whenever Tx_busy=0 SHALL obtain back-to-back frames with no gap.

Reset
REQ-023 Asserting rst=0 SHALL immediately force tx=1, Tx_busy=0, tx_done=0, state IDLE, and clear the baud counter, bit index and holding register.
REQ-024 Reset mid-frame SHALL abort the frame, with no partial resumption after release.
REQ-025 The first byte SHALL be accepted no earlier than the first rising edge after rst returns to 1.

Structure
REQ-026 A shared package uart_pkg SHALL hold the FSM state encodings, the default CLKS_PER_BIT constant and the PARITY_EN encodings, for reuse by a matching receiver.
REQ-027 The baud counter SHALL be one sub-module, uart_baud_tick, with inputs clk, rst and restart, and a one-cycle tick output on count CLKS_PER_BIT-1.
REQ-028 The counter width SHALL be $clog2(CLKS_PER_BIT).

Verification
REQ-029 Single byte: CLKS_PER_BIT=4, PARITY_EN=0, din=0xA5 strobed at edge N -> tx reads 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks, starting at edge N+1; tx_done pulses at clock N+40; Tx_busy is high only from edge N to edge N+1.
REQ-030 Parity: PARITY_EN=1, din=0x07 -> parity bit 1, frame is 44 clocks; din=0xA5 -> parity bit 0.
REQ-031 Back-to-back: 0x55 then 0xC3, the second strobed while the first is shifting -> stop bit of 0x55 is followed directly by the start bit of 0xC3, with no idle gap.
REQ-032 Overrun: 0x11 is accepted, then 0x22 is strobed while Tx_busy=1 -> only 0x11 and any earlier byte are transmitted, 0x22 never appears, and the holding register is unchanged.
REQ-033 Reset mid-frame: rst=0 during DATA bit 3 -> tx=1 asynchronously in the same cycle, Tx_busy=0; after release with no strobe, tx stays high.
REQ-034 Boundary: CLKS_PER_BIT=2 with 0xFF and 0x00 back-to-back -> exact 20-clock frames and correct levels.
